// File: rtl/mult_result_checker_if.sv
// Snoop bus between the multiplier stream and its result checker:
// operand issue (op_valid/op_a/op_b) and result return (res_valid/res_data).
interface mult_result_checker_if #(
    parameter int WIDTH = 32
);
    logic                 op_valid;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 res_valid;
    logic [2*WIDTH-1:0]   res_data;

    // Side that observes the multiplier traffic (bench or multiplier wrapper).
    modport master (
        output op_valid, op_a, op_b, res_valid, res_data
    );

    // Checker side.
    modport slave (
        input  op_valid, op_a, op_b, res_valid, res_data
    );
endinterface

// File: rtl/mult_result_checker.sv
// In-order result checker for the pipelined multiplier stream.
// Queues snooped operand pairs, pops one per returned result and compares it
// against the exact signed product. Keeps saturating pass/fail counters, sticky
// protocol errors and a run-level pass flag.
// Optional feature: define MULT_CHK_CAPTURE_EN to latch the first mismatching
// operands/result of a run into cap_*; otherwise cap_* are tied to 0.
module mult_result_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    mult_result_checker_if.slave mon,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         pass_cnt,
    output logic [15:0]         fail_cnt,
    output logic                err_overflow,
    output logic                err_underflow,
    output logic                err_timeout,
    output logic                cap_valid,
    output logic [WIDTH-1:0]    cap_a,
    output logic [WIDTH-1:0]    cap_b,
    output logic [2*WIDTH-1:0]  cap_got
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [TW-1:0]        to_cnt;
    logic                 cmp_valid, cmp_under;
    logic [WIDTH-1:0]     cmp_a, cmp_b;
    logic [2*WIDTH-1:0]   cmp_got, cmp_exp, head;
    logic                 active, empty, full;
    logic                 pop_req, pop, underflow, push_req, push, overflow;
    logic                 timeout_hit, match;

    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head     = mem[rd_ptr[AW-1:0]];

    // A result with nothing queued is an underflow; it never bypasses a same-cycle push.
    assign pop_req   = active && mon.res_valid;
    assign pop       = pop_req && !empty;
    assign underflow = pop_req && empty;
    assign push_req  = (state == S_RUN) && mon.op_valid;
    assign push      = push_req && (!full || pop);
    assign overflow  = push_req && full && !pop;

    assign timeout_hit = active && !empty && !mon.res_valid && (to_cnt == TW'(TIMEOUT - 1));

    // Exact signed product: sign-extend both operands to the full result width.
    assign cmp_exp = {{WIDTH{cmp_a[WIDTH-1]}}, cmp_a} * {{WIDTH{cmp_b[WIDTH-1]}}, cmp_b};
    assign match   = (cmp_got == cmp_exp);

    assign busy = active;
    assign done = (state == S_DONE);

    // Run-control next state; start overrides everything, including stop.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (timeout_hit) state_nxt = S_DONE;
                         else if (stop)   state_nxt = S_DRAIN;
                S_DRAIN: if (timeout_hit || (empty && !cmp_valid && !pop_req)) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // State register and registered run verdict.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the first branch inside the clocked block.
        if (!rst) begin
            state <= S_IDLE;
            pass  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= state_nxt;
            pass  <= (state_nxt == S_DONE) && (fail_cnt == 16'd0) && (pass_cnt != 16'd0) &&
                     !err_overflow && !err_underflow && !err_timeout && !timeout_hit;
        end
    end

    // Operand FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (push) mem[wr_ptr[AW-1:0]] <= {mon.op_a, mon.op_b};
    end

    // FIFO pointers; a restart or a timeout abandons whatever is queued.
    always_ff @(posedge clk) begin
        if (!rst || start || timeout_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Compare stage: register the popped operands and the returned result.
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            cmp_valid <= 1'b0;
            cmp_under <= 1'b0;
        end else begin
            cmp_valid <= pop_req;
            cmp_under <= empty;
        end
        cmp_a   <= head[2*WIDTH-1:WIDTH];
        cmp_b   <= head[WIDTH-1:0];
        cmp_got <= mon.res_data;
    end

    // Saturating pass/fail counters, updated one cycle after the result.
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (cmp_valid) begin
            if (cmp_under || !match) begin
                if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
            end else begin
                if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
            end
        end
    end

    // Sticky protocol errors and the no-progress watchdog.
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_timeout   <= 1'b0;
            to_cnt        <= '0;
        end else begin
            if (overflow)    err_overflow  <= 1'b1;
            if (underflow)   err_underflow <= 1'b1;
            if (timeout_hit) err_timeout   <= 1'b1;
            if (!active || empty || mon.res_valid) to_cnt <= '0;
            else                                   to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef MULT_CHK_CAPTURE_EN
    // First-mismatch capture; later mismatches in the same run leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            cap_valid <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_got   <= '0;
        end else if (cmp_valid && !cmp_under && !match && !cap_valid) begin
            cap_valid <= 1'b1;
            cap_a     <= cmp_a;
            cap_b     <= cmp_b;
            cap_got   <= cmp_got;
        end
    end
`else
    assign cap_valid = 1'b0;
    assign cap_a     = '0;
    assign cap_b     = '0;
    assign cap_got   = '0;
`endif
endmodule

// File: tb/tb_mult_result_checker.sv
// Directed bench for mult_result_checker: in-order checking, mismatch and
// capture, overflow, underflow, timeout, start/stop priority and mid-run reset.
module tb_mult_result_checker;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic        busy, done, pass;
    logic [15:0] pass_cnt, fail_cnt;
    logic        err_overflow, err_underflow, err_timeout;
    logic        cap_valid;
    logic [W-1:0]   cap_a, cap_b;
    logic [2*W-1:0] cap_got;
    int n_checks = 0;
    int n_fail   = 0;

    mult_result_checker_if #(.WIDTH(W)) bus ();

    mult_result_checker #(.WIDTH(W), .DEPTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mon(bus),
        .busy(busy), .done(done), .pass(pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_timeout(err_timeout),
        .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b), .cap_got(cap_got)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = 1'b1; bus.op_a = a; bus.op_b = b;
        tick(1);
        bus.op_valid = 1'b0;
    endtask

    task automatic send_res(input logic [2*W-1:0] d);
        bus.res_valid = 1'b1; bus.res_data = d;
        tick(1);
        bus.res_valid = 1'b0;
    endtask

    task automatic send_both(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] d);
        bus.op_valid = 1'b1; bus.op_a = a; bus.op_b = b;
        bus.res_valid = 1'b1; bus.res_data = d;
        tick(1);
        bus.op_valid = 1'b0; bus.res_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick(1);
        check("wait_done", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.res_valid = 1'b0; bus.res_data = '0;
        tick(2);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_cnts", {32'd0, pass_cnt, fail_cnt}, 64'd0);
        check("rst_errs", {61'd0, err_overflow, err_underflow, err_timeout}, 64'd0);
        check("rst_cap", 64'(cap_valid), 64'd0);
        rst = 1'b1;
        tick(1);

        // 1: four corner-value products, all correct.
        pulse_start();
        check("t1_busy", 64'(busy), 64'd1);
        send_op(32'd0, 32'd123);
        send_op(32'hFFFF_FFFF, 32'd1);
        send_op(32'h7FFF_FFFF, 32'd1);
        send_op(32'h8000_0000, 32'hFFFF_FFFF);
        tick(3);
        send_res(64'd0);
        send_res(64'hFFFF_FFFF_FFFF_FFFF);
        send_res(64'h0000_0000_7FFF_FFFF);
        send_res(64'h0000_0000_8000_0000);
        pulse_stop();
        wait_done(20);
        check("t1_pass_cnt", 64'(pass_cnt), 64'd4);
        check("t1_fail_cnt", 64'(fail_cnt), 64'd0);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_busy_off", 64'(busy), 64'd0);

        // 2: mismatch, then a good result, then a second mismatch.
        pulse_start();
        check("t2_cleared", {32'd0, pass_cnt, fail_cnt}, 64'd0);
        send_op(32'd5, 32'hFFFF_FFFD);
        send_res(64'hFFFF_FFFF_FFFF_FFF0);
        tick(1);
        check("t2_fail1", 64'(fail_cnt), 64'd1);
        check("t2_pass0", 64'(pass_cnt), 64'd0);
`ifdef MULT_CHK_CAPTURE_EN
        check("t2_cap_valid", 64'(cap_valid), 64'd1);
        check("t2_cap_a", 64'(cap_a), 64'd5);
        check("t2_cap_b", 64'(cap_b), 64'hFFFF_FFFD);
        check("t2_cap_got", cap_got, 64'hFFFF_FFFF_FFFF_FFF0);
`else
        check("t2_cap_off", {cap_valid, 31'd0, cap_a ^ cap_b}, 64'd0);
`endif
        send_op(32'd2, 32'd3);
        send_op(32'd7, 32'd7);
        send_res(64'd6);
        send_res(64'd0);
        pulse_stop();
        wait_done(20);
        check("t2_fail2", 64'(fail_cnt), 64'd2);
        check("t2_pass1", 64'(pass_cnt), 64'd1);
        check("t2_pass_flag", 64'(pass), 64'd0);
`ifdef MULT_CHK_CAPTURE_EN
        check("t2_cap_keep_a", 64'(cap_a), 64'd5);
`endif

        // 3: overflow on the 17th operand; first 16 still checked.
        pulse_start();
        for (int i = 1; i <= 16; i++) send_op(W'(i), 32'd2);
        check("t3_no_ovf", 64'(err_overflow), 64'd0);
        send_op(32'd17, 32'd2);
        check("t3_ovf", 64'(err_overflow), 64'd1);
        for (int i = 1; i <= 16; i++) send_res(64'(2 * i));
        tick(1);
        check("t3_pass_cnt", 64'(pass_cnt), 64'd16);
        check("t3_fail_cnt", 64'(fail_cnt), 64'd0);
        pulse_stop();
        wait_done(20);
        check("t3_pass_flag", 64'(pass), 64'd0);

        // 4: underflow, and empty-FIFO push+pop in the same cycle.
        pulse_start();
        send_res(64'd0);
        check("t4_unf", 64'(err_underflow), 64'd1);
        tick(1);
        check("t4_fail1", 64'(fail_cnt), 64'd1);
        check("t4_pass0", 64'(pass_cnt), 64'd0);
        send_both(32'd3, 32'd4, 64'd12);
        send_res(64'd12);
        tick(1);
        check("t4_fail2", 64'(fail_cnt), 64'd2);
        check("t4_pass1", 64'(pass_cnt), 64'd1);

        // start and stop together: start wins, the run stays in RUN.
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        tick(2);
        check("t4_start_wins", {62'd0, busy, done}, 64'd2);
        check("t4_restart_clr", {32'd0, pass_cnt, fail_cnt}, 64'd0);
        pulse_stop();
        wait_done(10);
        check("t4_empty_run", 64'(pass), 64'd0);

        // 5: timeout with one op outstanding; late result is ignored.
        pulse_start();
        send_op(32'd1, 32'd1);
        pulse_stop();
        tick(70);
        check("t5_timeout", 64'(err_timeout), 64'd1);
        check("t5_done", 64'(done), 64'd1);
        check("t5_pass", 64'(pass), 64'd0);
        send_res(64'd1);
        tick(2);
        check("t5_late_ign", {32'd0, pass_cnt, fail_cnt}, 64'd0);
        check("t5_no_unf", 64'(err_underflow), 64'd0);

        // 6: reset mid-run with three ops outstanding.
        pulse_start();
        for (int i = 0; i < 4; i++) send_op(W'(i + 1), 32'd3);
        send_res(64'd3);
        tick(1);
        check("t6_pre_pass", 64'(pass_cnt), 64'd1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("t6_rst_cnts", {32'd0, pass_cnt, fail_cnt}, 64'd0);
        check("t6_rst_state", {61'd0, busy, done, pass}, 64'd0);
        send_res(64'd6);
        tick(2);
        check("t6_after_rst", {32'd0, pass_cnt, fail_cnt}, 64'd0);
        check("t6_after_errs", {61'd0, err_overflow, err_underflow, err_timeout}, 64'd0);
        check("t6_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
